frame_timing_gen: RTL and testbench
===================================

Name: frame_timing_gen

Overview:
Frame/line timing transmitter for the EyeTracker pixel path. It generates the FVAL/LVAL/DVAL framing, the VSYNC pulse, a two-pixel-per-clock (left/right) data stream and a cyclic frame number. Downstream, the frame-control and centroid logic consume these signals. The block is the stimulus source for on-chip bring-up and bench verification of the receive side, and it replaces the camera front end when that front end is bypassed.

Parameters:
H_ACTIVE, 640, active pixels per line; must be even; 2 pixels per clock.
V_ACTIVE, 480, active lines per frame.
H_BLANK, 16, blank clocks between active lines (FVAL high, LVAL low); must be 1 or more.
V_BLANK, 32, blank clocks between frames (FVAL low); must be 1 or more.
MAX_FRAME, 3, frame-number modulus; must be 2 or more.
DATA_WIDTH, 8, bits per pixel.
BOX_X0, BOX_Y0, BOX_W, BOX_H, 300/220/40/40, bright-box position and size for pattern 3.

Ports:
CCLK  in  1  pixel-pair clock
RST  in  1  asynchronous reset, active-high
iEN  in  1  run enable; level-sensitive
iPATTERN  in  2  0 = zero, 1 = horizontal ramp, 2 = vertical ramp, 3 = bright box
oVSYNC  out  1  one-cycle pulse at frame start
oFVAL  out  1  frame valid
oLVAL  out  1  line valid
oDVAL  out  1  data valid; equals oLVAL
oDATA_L  out  DATA_WIDTH  even pixel (x = 2*col)
oDATA_R  out  DATA_WIDTH  odd pixel (x = 2*col+1)
oFRAME_NUM  out  max(1,$clog2(MAX_FRAME))  number of the frame being sent
oFRAME_DONE  out  1  one-cycle pulse on the cycle oFVAL falls

Behaviour:
- All outputs are registered. While RST is high, every output is 0, the state is IDLE and all counters are 0. Reset asserted mid-frame aborts the frame at once, with no partial-frame pulses.
- State machine:
  - IDLE: all outputs 0. When iEN=1, go to FSTART.
  - FSTART: lasts 1 cycle; oVSYNC=1; iPATTERN is latched here and held for the whole frame. Go to LINE with col=0, row=0.
  - LINE: lasts H_ACTIVE/2 cycles; oFVAL=oLVAL=oDVAL=1; col increments each cycle. After the last col: go to HBLANK if row<V_ACTIVE-1, otherwise go to VBLANK.
  - HBLANK: lasts H_BLANK cycles; oFVAL=1, oLVAL=0; row increments on exit; then go to LINE.
  - VBLANK: lasts V_BLANK cycles; oFVAL=0. The first VBLANK cycle has oFRAME_DONE=1. On exit, oFRAME_NUM increments and wraps from MAX_FRAME-1 to 0. Then go to FSTART if iEN=1, otherwise IDLE.
- Latency: iEN rising while in IDLE at edge t gives oVSYNC=1 after edge t+1 and oFVAL=1 after edge t+2.
- Frame period: 1 + V_ACTIVE*H_ACTIVE/2 + (V_ACTIVE-1)*H_BLANK + V_BLANK clocks.
- iEN dropping mid-frame: the current frame completes, including VBLANK, and then the block goes to IDLE. iEN changes during VBLANK are sampled only at VBLANK exit.
- oFRAME_NUM: 0 after reset; constant while oFVAL=1; held while in IDLE.
- Pattern data; x and y are the pixel coordinates, truncated to DATA_WIDTH:
  - Pattern 0: all pixels 0.
  - Pattern 1: pixel value = x.
  - Pattern 2: pixel value = y.
  - Pattern 3: pixel value = all ones if BOX_X0 <= x < BOX_X0+BOX_W and BOX_Y0 <= y < BOX_Y0+BOX_H, otherwise 0.
  - oDATA_L/R are 0 whenever oLVAL=0.
- Counters are sized with $clog2 of their terminal count. There is no overflow; all wrap points are explicit compares.

Decomposition:
- Shared package ftg_pkg holds the state encoding (IDLE, FSTART, LINE, HBLANK, VBLANK as a 3-bit localparam set), the pattern codes PAT_ZERO, PAT_HRAMP, PAT_VRAMP and PAT_BOX, and a clog2 helper.
- One sub-module, ftg_pattern_gen, computes oDATA_L/R from (pattern, col, row), with the output register taken inside it so that data aligns with oLVAL.

Test Plan:
(All use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=3, MAX_FRAME=3.)
- Reset released, then iEN=1 held -> oVSYNC pulses at cycle 1, oFVAL rises at cycle 2, frame period exactly 26 clocks, and each line has 4 LVAL cycles separated by 2 blank cycles.
- iEN=1 held for 4 frames -> oFRAME_NUM reads 0,1,2,0; oFRAME_DONE gives exactly one pulse per frame, coincident with the oFVAL fall.
- Pattern 1 -> each line shows L/R pairs (0,1),(2,3),(4,5),(6,7). Pattern 2 -> line 3 data is all 3.
- Pattern 3 with BOX_X0=2, BOX_Y0=1, BOX_W=4, BOX_H=2 -> exactly 8 pixels equal 255 (rows 1-2, x 2-5); all others are 0.
- iEN dropped in line 1 and iPATTERN changed mid-frame -> the frame completes unchanged with the old pattern, the block reaches IDLE after VBLANK, and no further oVSYNC occurs.
- RST pulsed mid-LINE -> all outputs 0 on the next sample. After release with iEN=1, the next frame restarts from FSTART with oFRAME_NUM=0.

Source files
------------

// File: rtl/ftg_pkg.sv
// Shared definitions for the frame timing generator: FSM state encoding,
// test-pattern codes and a width helper for counter sizing.
package ftg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FSTART = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4
  } ftg_state_e;

  localparam logic [1:0] PAT_ZERO  = 2'd0;
  localparam logic [1:0] PAT_HRAMP = 2'd1;
  localparam logic [1:0] PAT_VRAMP = 2'd2;
  localparam logic [1:0] PAT_BOX   = 2'd3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/frame_timing_gen_if.sv
// Control and pixel-stream bundle between the frame timing generator
// (master) and its consumer or stimulus driver (slave).
interface frame_timing_gen_if
  import ftg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 3
);
  localparam int FN_W = clog2(MAX_FRAME);

  logic                  iEN;
  logic [1:0]            iPATTERN;
  logic                  oVSYNC;
  logic                  oFVAL;
  logic                  oLVAL;
  logic                  oDVAL;
  logic [DATA_WIDTH-1:0] oDATA_L;
  logic [DATA_WIDTH-1:0] oDATA_R;
  logic [FN_W-1:0]       oFRAME_NUM;
  logic                  oFRAME_DONE;

  modport master (
    input  iEN, iPATTERN,
    output oVSYNC, oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oFRAME_NUM, oFRAME_DONE
  );

  modport slave (
    output iEN, iPATTERN,
    input  oVSYNC, oFVAL, oLVAL, oDVAL, oDATA_L, oDATA_R, oFRAME_NUM, oFRAME_DONE
  );

endinterface

// File: rtl/ftg_pattern_gen.sv
// Pixel-pair pattern source: maps (pattern, col, row) to the even/odd pixel
// values and registers them so they line up with the registered LVAL.
module ftg_pattern_gen
  import ftg_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COL_W      = 8,
  parameter int ROW_W      = 9,
  parameter int BOX_X0     = 300,
  parameter int BOX_Y0     = 220,
  parameter int BOX_W      = 40,
  parameter int BOX_H      = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_p0,
  input  logic [1:0]            pattern,
  input  logic [COL_W-1:0]      col,
  input  logic [ROW_W-1:0]      row,
  output logic [DATA_WIDTH-1:0] data_l_p1,
  output logic [DATA_WIDTH-1:0] data_r_p1
);

  function automatic logic [DATA_WIDTH-1:0] pixel(input logic [1:0] pat,
                                                  input int x, input int y);
    logic in_box;
    in_box = (x >= BOX_X0) && (x < BOX_X0 + BOX_W) &&
             (y >= BOX_Y0) && (y < BOX_Y0 + BOX_H);
    case (pat)
      PAT_HRAMP: pixel = DATA_WIDTH'(x);
      PAT_VRAMP: pixel = DATA_WIDTH'(y);
      PAT_BOX:   pixel = in_box ? '1 : '0;
      default:   pixel = '0;
    endcase
  endfunction

  int x_l_p0;
  int x_r_p0;
  int y_p0;

  always_comb begin
    x_l_p0 = int'(col) * 2;
    x_r_p0 = x_l_p0 + 1;
    y_p0   = int'(row);
  end

  // p0 -> p1: data is forced to zero outside active pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_l_p1 <= '0;
      data_r_p1 <= '0;
    end else if (vld_p0) begin
      data_l_p1 <= pixel(pattern, x_l_p0, y_p0);
      data_r_p1 <= pixel(pattern, x_r_p0, y_p0);
    end else begin
      data_l_p1 <= '0;
      data_r_p1 <= '0;
    end
  end

endmodule

// File: rtl/frame_timing_gen.sv
// Frame/line timing transmitter: FVAL/LVAL/DVAL framing, VSYNC, frame number
// and a two-pixel-per-clock test pattern stream.
module frame_timing_gen
  import ftg_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 32,
  parameter int MAX_FRAME  = 3,
  parameter int DATA_WIDTH = 8,
  parameter int BOX_X0     = 300,
  parameter int BOX_Y0     = 220,
  parameter int BOX_W      = 40,
  parameter int BOX_H      = 40
) (
  input logic               CCLK,
  input logic               RST,
  frame_timing_gen_if.master bus
);

  localparam int COLS  = H_ACTIVE / 2;
  localparam int COL_W = clog2(COLS);
  localparam int ROW_W = clog2(V_ACTIVE);
  localparam int BLK_W = clog2((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int FN_W  = clog2(MAX_FRAME);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [BLK_W-1:0] HB_LAST  = BLK_W'(H_BLANK - 1);
  localparam logic [BLK_W-1:0] VB_LAST  = BLK_W'(V_BLANK - 1);
  localparam logic [FN_W-1:0]  FN_LAST  = FN_W'(MAX_FRAME - 1);

  ftg_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [FN_W-1:0]  fnum_q, fnum_d;
  logic [1:0]       pat_q, pat_d;

  logic vsync_d, fval_d, lval_d, done_d;

  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      blk_q   <= '0;
      fnum_q  <= '0;
      pat_q   <= PAT_ZERO;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      blk_q   <= blk_d;
      fnum_q  <= fnum_d;
      pat_q   <= pat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    blk_d   = blk_q;
    fnum_d  = fnum_q;
    pat_d   = pat_q;
    case (state_q)
      IDLE: begin
        if (bus.iEN) state_d = FSTART;
      end
      FSTART: begin
        pat_d   = bus.iPATTERN;
        col_d   = '0;
        row_d   = '0;
        blk_d   = '0;
        state_d = LINE;
      end
      LINE: begin
        if (col_q == COL_LAST) begin
          col_d   = '0;
          blk_d   = '0;
          state_d = (row_q == ROW_LAST) ? VBLANK : HBLANK;
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end
      HBLANK: begin
        if (blk_q == HB_LAST) begin
          blk_d   = '0;
          row_d   = row_q + ROW_W'(1);
          state_d = LINE;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      VBLANK: begin
        // iEN only matters here at the very end of the frame
        if (blk_q == VB_LAST) begin
          blk_d   = '0;
          fnum_d  = (fnum_q == FN_LAST) ? '0 : fnum_q + FN_W'(1);
          state_d = bus.iEN ? FSTART : IDLE;
        end else begin
          blk_d = blk_q + BLK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vsync_d = (state_q == FSTART);
    fval_d  = (state_q == LINE) || (state_q == HBLANK);
    lval_d  = (state_q == LINE);
    done_d  = (state_q == VBLANK) && (blk_q == '0);
  end

  logic            vsync_p1, fval_p1, lval_p1, done_p1;
  logic [FN_W-1:0] fnum_p1;

  // state decode -> registered outputs (one cycle behind the state)
  always_ff @(posedge CCLK or posedge RST) begin
    if (RST) begin
      vsync_p1 <= 1'b0;
      fval_p1  <= 1'b0;
      lval_p1  <= 1'b0;
      done_p1  <= 1'b0;
      fnum_p1  <= '0;
    end else begin
      vsync_p1 <= vsync_d;
      fval_p1  <= fval_d;
      lval_p1  <= lval_d;
      done_p1  <= done_d;
      fnum_p1  <= fnum_q;
    end
  end

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_l_p1, data_r_p1;

  assign vld_p0 = (state_q == LINE);

  ftg_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .COL_W      (COL_W),
    .ROW_W      (ROW_W),
    .BOX_X0     (BOX_X0),
    .BOX_Y0     (BOX_Y0),
    .BOX_W      (BOX_W),
    .BOX_H      (BOX_H)
  ) u_pattern (
    .clk       (CCLK),
    .rst       (RST),
    .vld_p0    (vld_p0),
    .pattern   (pat_q),
    .col       (col_q),
    .row       (row_q),
    .data_l_p1 (data_l_p1),
    .data_r_p1 (data_r_p1)
  );

  assign bus.oVSYNC      = vsync_p1;
  assign bus.oFVAL       = fval_p1;
  assign bus.oLVAL       = lval_p1;
  assign bus.oDVAL       = lval_p1;
  assign bus.oFRAME_DONE = done_p1;
  assign bus.oFRAME_NUM  = fnum_p1;
  assign bus.oDATA_L     = data_l_p1;
  assign bus.oDATA_R     = data_r_p1;

endmodule

// File: tb/tb_frame_timing_gen.sv
// Bench for frame_timing_gen: directed scenarios plus randomized enable,
// pattern and reset activity against a frame-position reference model.
module tb_frame_timing_gen;
  import ftg_pkg::*;

  localparam int H_ACTIVE   = 8;
  localparam int V_ACTIVE   = 4;
  localparam int H_BLANK    = 2;
  localparam int V_BLANK    = 3;
  localparam int MAX_FRAME  = 3;
  localparam int DATA_WIDTH = 8;
  localparam int BOX_X0 = 2, BOX_Y0 = 1, BOX_W = 4, BOX_H = 2;
  localparam int COLS     = H_ACTIVE / 2;
  localparam int LINE_LEN = COLS + H_BLANK;
  localparam int PERIOD   = 1 + V_ACTIVE * COLS + (V_ACTIVE - 1) * H_BLANK + V_BLANK;

  logic CCLK = 1'b0;
  logic RST  = 1'b1;

  frame_timing_gen_if #(.DATA_WIDTH(DATA_WIDTH), .MAX_FRAME(MAX_FRAME)) bus ();

  frame_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK),
    .MAX_FRAME(MAX_FRAME), .DATA_WIDTH(DATA_WIDTH),
    .BOX_X0(BOX_X0), .BOX_Y0(BOX_Y0), .BOX_W(BOX_W), .BOX_H(BOX_H)
  ) dut (
    .CCLK (CCLK),
    .RST  (RST),
    .bus  (bus)
  );

  always #5 CCLK = ~CCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: position within the frame (-1 = idle). Outputs show the
  // position held before the most recent clock edge.
  int m_pos, m_prev, m_fnum, m_fnum_out, m_pat;

  task automatic model_reset();
    m_pos = -1; m_prev = -1; m_fnum = 0; m_fnum_out = 0; m_pat = 0;
  endtask

  task automatic model_edge();
    if (RST) begin
      model_reset();
      return;
    end
    m_prev     = m_pos;
    m_fnum_out = m_fnum;
    if (m_pos == 0) m_pat = int'(bus.iPATTERN);
    if (m_pos == -1) begin
      if (bus.iEN) m_pos = 0;
    end else if (m_pos == PERIOD - 1) begin
      m_fnum = (m_fnum + 1) % MAX_FRAME;
      m_pos  = bus.iEN ? 0 : -1;
    end else begin
      m_pos++;
    end
  endtask

  function automatic int pix(input int pat, input int x, input int y);
    case (pat)
      1: return x % 256;
      2: return y % 256;
      3: return (x >= BOX_X0 && x < BOX_X0 + BOX_W && y >= BOX_Y0 && y < BOX_Y0 + BOX_H) ? 255 : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_expect(output logic [4:0] ctrl, output logic [15:0] data);
    bit vs, fv, lv, dn;
    int r, row, c;
    vs = (m_prev == 0);
    fv = (m_prev >= 1) && (m_prev <= PERIOD - V_BLANK - 1);
    dn = (m_prev == PERIOD - V_BLANK);
    lv = 1'b0;
    data = '0;
    if (fv) begin
      r   = m_prev - 1;
      row = r / LINE_LEN;
      c   = r % LINE_LEN;
      lv  = (c < COLS);
      if (lv) data = {8'(pix(m_pat, 2 * c, row)), 8'(pix(m_pat, 2 * c + 1, row))};
    end
    ctrl = {vs, fv, lv, lv, dn};
  endtask

  int cyc = 0;
  int vsync_cnt = 0, done_cnt = 0, box_cnt = 0;
  int vs_cyc[$];
  int fn_seen[$];

  task automatic check_zero(input string tag);
    chk(tag, 64'({bus.oVSYNC, bus.oFVAL, bus.oLVAL, bus.oDVAL, bus.oFRAME_DONE,
                  bus.oDATA_L, bus.oDATA_R, bus.oFRAME_NUM}), 64'd0);
  endtask

  task automatic tick();
    logic [4:0]  e_ctrl;
    logic [15:0] e_data;
    @(posedge CCLK);
    model_edge();
    #1;
    cyc++;
    model_expect(e_ctrl, e_data);
    chk("ctrl", 64'({bus.oVSYNC, bus.oFVAL, bus.oLVAL, bus.oDVAL, bus.oFRAME_DONE}), 64'(e_ctrl));
    chk("data", 64'({bus.oDATA_L, bus.oDATA_R}), 64'(e_data));
    chk("fnum", 64'(bus.oFRAME_NUM), 64'(m_fnum_out));
    if (bus.oVSYNC) begin
      vsync_cnt++;
      vs_cyc.push_back(cyc);
      fn_seen.push_back(int'(bus.oFRAME_NUM));
    end
    if (bus.oFRAME_DONE) done_cnt++;
    if (bus.oLVAL && bus.oDATA_L == 8'hFF) box_cnt++;
    if (bus.oLVAL && bus.oDATA_R == 8'hFF) box_cnt++;
  endtask

  initial begin
    model_reset();
    bus.iEN = 1'b0;
    bus.iPATTERN = 2'd0;
    repeat (3) tick();
    check_zero("reset_hold");

    // Continuous run of four frames with the horizontal ramp
    bus.iEN = 1'b1;
    bus.iPATTERN = 2'd1;
    RST = 1'b0;
    vsync_cnt = 0; done_cnt = 0;
    vs_cyc.delete(); fn_seen.delete();
    tick();
    chk("vsync_lat0", 64'(bus.oVSYNC), 64'd0);
    tick();
    chk("vsync_lat1", 64'(bus.oVSYNC), 64'd1);
    tick();
    chk("fval_lat2", 64'(bus.oFVAL), 64'd1);
    repeat (4 * PERIOD + 1 - 3) tick();
    chk("vsync_cnt4", 64'(vsync_cnt), 64'd4);
    chk("done_cnt4", 64'(done_cnt), 64'd4);
    for (int i = 1; i < vs_cyc.size(); i++)
      chk("period", 64'(vs_cyc[i] - vs_cyc[i-1]), 64'(PERIOD));
    chk("fn_list_len", 64'(fn_seen.size()), 64'd4);
    for (int i = 0; i < fn_seen.size() && i < 4; i++)
      chk("fn_seq", 64'(fn_seen[i]), 64'(i % MAX_FRAME));

    bus.iEN = 1'b0;
    repeat (40) tick();
    chk("idle_fval", 64'(bus.oFVAL), 64'd0);

    // Single bright-box frame
    bus.iPATTERN = 2'd3;
    bus.iEN = 1'b1;
    box_cnt = 0;
    repeat (2) tick();
    bus.iEN = 1'b0;
    repeat (35) tick();
    chk("box_pixels", 64'(box_cnt), 64'd8);

    // Single vertical-ramp frame
    bus.iPATTERN = 2'd2;
    bus.iEN = 1'b1;
    repeat (2) tick();
    bus.iEN = 1'b0;
    repeat (35) tick();

    // Enable dropped and pattern changed while in line 1
    bus.iPATTERN = 2'd1;
    bus.iEN = 1'b1;
    repeat (10) tick();
    bus.iEN = 1'b0;
    bus.iPATTERN = 2'd3;
    box_cnt = 0; vsync_cnt = 0;
    repeat (40) tick();
    chk("drop_no_vsync", 64'(vsync_cnt), 64'd0);
    chk("drop_old_pat", 64'(box_cnt), 64'd0);
    chk("drop_idle", 64'(bus.oFVAL), 64'd0);

    // Asynchronous reset in the middle of a line of the second frame
    bus.iEN = 1'b1;
    repeat (PERIOD + 6) tick();
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_zero("rst_async");
    repeat (2) tick();
    RST = 1'b0;
    tick();
    tick();
    chk("rst_vsync", 64'(bus.oVSYNC), 64'd1);
    chk("rst_fnum", 64'(bus.oFRAME_NUM), 64'd0);

    // Randomized enable, pattern and occasional reset
    repeat (1500) begin
      if ($urandom_range(0, 39) == 0) bus.iEN = ~bus.iEN;
      bus.iPATTERN = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_zero("rst_rand");
        tick();
        RST = 1'b0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
